// File: rtl/cordic_ci_pkg.sv
// Shared types and constants for the cosine custom-instruction initiator.
// The slave sequencing FSM walks IDLE -> LOAD -> RUN -> CAPTURE once per operand.
package cordic_ci_pkg;

    localparam int FP32_W     = 32;
    localparam int N_ITER_DEF = 16;
    localparam int ITER_W     = $clog2(N_ITER_DEF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_ci_out_fifo.sv
// Small synchronous result FIFO with a registered head word.
// Simultaneous read and write are both honoured, including when the FIFO is full.
module cordic_ci_out_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   head_q, head_d;
    logic                wr_ok, rd_ok;
    logic [PTR_W-1:0]    wr_idx, rd_idx_nxt;

    // The extra top pointer bit tells a full FIFO apart from an empty one.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign rd_ok  = rd_i & ~empty_o;
    assign wr_ok  = wr_i & (~full_o | rd_ok);
    assign wr_idx = wr_ptr_q[PTR_W-1:0];

    // Head word for the next cycle: a write into the slot about to become head bypasses memory.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, wr_ok};
        rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, rd_ok};
        rd_idx_nxt = rd_ptr_d[PTR_W-1:0];
        head_d     = mem_q[rd_idx_nxt];
        if (wr_ok && (wr_idx == rd_idx_nxt)) begin
            head_d = wr_data_i;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            if (wr_ok) begin
                mem_q[wr_idx] <= wr_data_i;
            end
        end
    end

    assign head_o = head_q;

endmodule

// File: rtl/cordic_ci_master.sv
// Initiator for the multi-cycle cosine custom instruction: loads, iterates and captures one
// cordic slave per operand and queues each result in a small output FIFO.
module cordic_ci_master
    import cordic_ci_pkg::*;
#(
    parameter int DATA_W    = FP32_W,
    parameter int N_ITER    = N_ITER_DEF,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              ci_aclr,
    output logic              ci_clk_en,
    output logic [DATA_W-1:0] ci_dataa,
    input  logic [DATA_W-1:0] ci_result,
    output state_t            dbg_state
);

    // Both streams: a word moves on a rising edge where valid and ready are both high; valid
    // never waits for ready, and neither ready nor valid here is derived from the other side.

    localparam int              CNT_W    = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_ITER - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic [DATA_W-1:0]  operand_q, operand_d;
    logic               ready_int;
    logic               fifo_wr, fifo_full, fifo_empty;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q   <= ST_IDLE;
            iter_q    <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            operand_q <= operand_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        operand_d = operand_q;
        ready_int = 1'b0;
        ci_aclr   = 1'b1;
        ci_clk_en = 1'b0;
        fifo_wr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready_int = 1'b1;
                if (in_valid) begin
                    operand_d = in_data;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                iter_d  = CNT_LOAD;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                ci_aclr   = 1'b0;
                ci_clk_en = 1'b1;
                if (iter_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    iter_d = iter_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                // Slave is frozen at its final index here, so holding this state is a safe stall.
                ci_aclr   = 1'b0;
                ready_int = ~fifo_full;
                if (~fifo_full | out_ready) begin
                    fifo_wr = 1'b1;
                    if (ready_int && in_valid) begin
                        operand_d = in_data;
                        state_d   = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    cordic_ci_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clock     (clock),
        .aclr_n    (aclr_n),
        .wr_i      (fifo_wr),
        .wr_data_i (ci_result),
        .rd_i      (out_ready),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (out_data)
    );

    // Held low while reset is asserted so nothing can be offered a handshake during reset.
    assign in_ready  = ready_int & aclr_n;
    assign out_valid = ~fifo_empty;
    assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
    assign ci_dataa  = operand_q;
    assign dbg_state = state_q;

endmodule
